// File: rtl/remap_table_scanner.sv
// Walks the channel remap table from index 0 to a latched limit and streams
// {index, remapped} words over a valid/ready port, optionally rescanning forever.
module remap_table_scanner #(
    parameter int unsigned NUM_ENTRIES = 128,
    parameter int unsigned IDX_W       = 7
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_continuous,
    input  logic             i_abort,
    input  logic [IDX_W-1:0] i_last_idx,
    output logic [IDX_W-1:0] o_index_number,
    input  logic [IDX_W-1:0] i_index_number_remapped,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [15:0]      o_m_data,
    output logic             o_busy,
    output logic             o_done,
    output logic [15:0]      o_pass_count
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_CAPT = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] r_lim;
    logic             r_abort;
    logic             r_m_valid;
    logic [15:0]      r_m_data;
    logic             r_done;
    logic [15:0]      r_pass_count;

    logic [IDX_W-1:0] w_lim_in;
    logic             w_abort_seen;
    logic             w_at_end;
    logic [15:0]      w_word;

    assign w_lim_in     = (i_last_idx > LAST_IDX) ? LAST_IDX : i_last_idx;
    // An abort arriving on the handshake cycle itself still ends the scan after this word.
    assign w_abort_seen = r_abort | i_abort;
    assign w_at_end     = (r_index == r_lim);
    assign w_word       = {1'b0, r_index, 1'b0, i_index_number_remapped};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_index      <= '0;
            r_lim        <= '0;
            r_abort      <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_done       <= 1'b0;
            r_pass_count <= '0;
        end else begin
            r_done <= 1'b0;
            if ((r_state != S_IDLE) && i_abort) begin
                r_abort <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_lim   <= w_lim_in;
                        r_index <= '0;
                        r_abort <= i_abort;
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_m_data  <= w_word;
                    r_m_valid <= 1'b1;
                    r_state   <= S_OUT;
                end
                S_OUT: begin
                    if (i_m_ready) begin
                        r_m_valid <= 1'b0;
                        if (w_abort_seen) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else if (w_at_end) begin
                            if (r_pass_count != 16'hFFFF) begin
                                r_pass_count <= r_pass_count + 16'd1;
                            end
                            r_done <= 1'b1;
                            if (i_continuous) begin
                                r_index <= '0;
                                r_state <= S_ADDR;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_index <= r_index + IDX_ONE;
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    r_abort <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_index_number = r_index;
    assign o_m_valid      = r_m_valid;
    assign o_m_data       = r_m_data;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = r_done;
    assign o_pass_count   = r_pass_count;

endmodule

// File: tb/tb_remap_table_scanner.sv
// Directed-plus-random bench: expected word streams are built from the table contents
// and scan limits, then compared against the words the DUT hands off.
module tb_remap_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        continuous = 1'b0;
    logic        abort = 1'b0;
    logic [6:0]  last_idx = 7'd0;
    logic        ready_a = 1'b1;
    logic        ready_b = 1'b1;

    logic [6:0]  tbl [128];
    logic [6:0]  idx_a, idx_b, remap_a, remap_b;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;
    logic [15:0] data_a, data_b, pc_a, pc_b;

    assign remap_a = tbl[idx_a];
    assign remap_b = tbl[idx_b];

    remap_table_scanner #(.NUM_ENTRIES(128), .IDX_W(7)) u_dut_a (
        .i_clk                   (clk),
        .i_reset                 (reset),
        .i_start                 (start_a),
        .i_continuous            (continuous),
        .i_abort                 (abort),
        .i_last_idx              (last_idx),
        .o_index_number          (idx_a),
        .i_index_number_remapped (remap_a),
        .o_m_valid               (valid_a),
        .i_m_ready               (ready_a),
        .o_m_data                (data_a),
        .o_busy                  (busy_a),
        .o_done                  (done_a),
        .o_pass_count            (pc_a)
    );

    remap_table_scanner #(.NUM_ENTRIES(64), .IDX_W(7)) u_dut_b (
        .i_clk                   (clk),
        .i_reset                 (reset),
        .i_start                 (start_b),
        .i_continuous            (1'b0),
        .i_abort                 (abort),
        .i_last_idx              (last_idx),
        .o_index_number          (idx_b),
        .i_index_number_remapped (remap_b),
        .o_m_valid               (valid_b),
        .i_m_ready               (ready_b),
        .o_m_data                (data_b),
        .o_busy                  (busy_b),
        .o_done                  (done_b),
        .o_pass_count            (pc_b)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt_a = 0;
    int done_cnt_b = 0;
    int exp_pass = 0;
    logic [15:0] got_a [$];
    logic [15:0] got_b [$];
    logic [15:0] exp_q [$];

    int          ready_mode = 0;
    logic        hold_en = 1'b0;
    logic [6:0]  hold_idx = 7'd0;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input int i);
        logic [6:0] ix;
        ix = 7'(i);
        return {1'b0, ix, 1'b0, tbl[ix]};
    endfunction

    // Expected stream: every pass visits indices 0..lim in order.
    task automatic build_exp(input int lim, input int passes);
        for (int p = 0; p < passes; p++)
            for (int i = 0; i <= lim; i++) exp_q.push_back(word_of(i));
    endtask

    task automatic cmp_words(input string tag);
        chk16({tag, "_count"}, 16'(got_a.size()), 16'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++)
            chk16($sformatf("%s_w%0d", tag, i), got_a[i], exp_q[i]);
        got_a.delete();
        exp_q.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a(input logic [6:0] li);
        tick();
        last_idx = li;
        start_a  = 1'b1;
        tick();
        start_a  = 1'b0;
    endtask

    task automatic wait_idle_a(input int budget, input string tag);
        int n = 0;
        @(negedge clk);
        while (busy_a && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk16({tag, "_idle"}, 16'(busy_a), 16'd0);
    endtask

    task automatic rand_table();
        for (int i = 0; i < 128; i++) tbl[i] = 7'($urandom);
    endtask

    // Consumer ready driver: always, toggling, hold-on-index, or random.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: ready_a = 1'b1;
                1: ready_a = ~ready_a;
                2: ready_a = !(hold_en && valid_a && data_a[14:8] == hold_idx);
                default: ready_a = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Word collector and stall-stability monitor.
    initial begin
        logic        prev_stall = 1'b0;
        logic        prev_reset = 1'b1;
        logic [15:0] prev_data = 16'd0;
        forever begin
            @(negedge clk);
            if (prev_stall && !prev_reset) begin
                chk16("stall_valid", 16'(valid_a), 16'd1);
                chk16("stall_data", data_a, prev_data);
            end
            if (valid_a && ready_a && !reset) got_a.push_back(data_a);
            if (done_a) done_cnt_a++;
            if (valid_b && ready_b && !reset) got_b.push_back(data_b);
            if (done_b) done_cnt_b++;
            prev_stall = valid_a && !ready_a;
            prev_data  = data_a;
            prev_reset = reset;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int li;
        for (int i = 0; i < 128; i++) tbl[i] = 7'(127 - i);

        repeat (3) tick();
        @(negedge clk);
        chk16("rst_index", 16'(idx_a), 16'd0);
        chk16("rst_valid", 16'(valid_a), 16'd0);
        chk16("rst_data", data_a, 16'd0);
        chk16("rst_busy", 16'(busy_a), 16'd0);
        chk16("rst_done", 16'(done_a), 16'd0);
        chk16("rst_pass", pc_a, 16'd0);
        tick();
        reset = 1'b0;

        // Full table, inverted contents, latency check on the first word.
        ready_mode = 0;
        done_cnt_a = 0;
        pulse_start_a(7'd127);
        @(negedge clk);
        chk16("lat_busy", 16'(busy_a), 16'd1);
        chk16("lat_idx", 16'(idx_a), 16'd0);
        chk16("lat_t0_valid", 16'(valid_a), 16'd0);
        @(negedge clk);
        chk16("lat_t1_valid", 16'(valid_a), 16'd0);
        @(negedge clk);
        chk16("lat_t2_valid", 16'(valid_a), 16'd1);
        chk16("lat_t2_data", data_a, 16'h007F);
        wait_idle_a(800, "full");
        if (got_a.size() == 128) begin
            chk16("full_first", got_a[0], 16'h007F);
            chk16("full_last", got_a[127], 16'h7F00);
        end
        build_exp(127, 1);
        cmp_words("full");
        exp_pass++;
        chk16("full_done", 16'(done_cnt_a), 16'd1);
        chk16("full_pass", pc_a, 16'(exp_pass));

        // Toggling ready, short prefix.
        rand_table();
        ready_mode = 1;
        done_cnt_a = 0;
        pulse_start_a(7'd3);
        wait_idle_a(200, "toggle");
        build_exp(3, 1);
        cmp_words("toggle");
        exp_pass++;
        chk16("toggle_done", 16'(done_cnt_a), 16'd1);
        chk16("toggle_pass", pc_a, 16'(exp_pass));

        // Continuous: three passes of two entries.
        ready_mode = 3;
        done_cnt_a = 0;
        continuous = 1'b1;
        pulse_start_a(7'd1);
        n = 0;
        while (done_cnt_a < 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk16("cont_two_passes", 16'(done_cnt_a >= 2), 16'd1);
        continuous = 1'b0;
        wait_idle_a(300, "cont");
        build_exp(1, 3);
        cmp_words("cont");
        exp_pass += 3;
        chk16("cont_done", 16'(done_cnt_a), 16'd3);
        chk16("cont_pass", pc_a, 16'(exp_pass));

        // Abort while word 5 is stalled.
        ready_mode = 2;
        hold_idx   = 7'd5;
        hold_en    = 1'b1;
        done_cnt_a = 0;
        pulse_start_a(7'd20);
        n = 0;
        while (!(valid_a && data_a[14:8] == 7'd5) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk16("abort_reach5", 16'(valid_a && data_a[14:8] == 7'd5), 16'd1);
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        hold_en = 1'b0;
        wait_idle_a(100, "abort");
        build_exp(5, 1);
        cmp_words("abort");
        chk16("abort_done", 16'(done_cnt_a), 16'd1);
        chk16("abort_pass", pc_a, 16'(exp_pass));

        // Start and abort together: exactly word 0.
        ready_mode = 0;
        done_cnt_a = 0;
        tick();
        last_idx = 7'd10;
        start_a  = 1'b1;
        abort    = 1'b1;
        tick();
        start_a  = 1'b0;
        abort    = 1'b0;
        wait_idle_a(100, "startabort");
        build_exp(0, 1);
        cmp_words("startabort");
        chk16("startabort_done", 16'(done_cnt_a), 16'd1);
        chk16("startabort_pass", pc_a, 16'(exp_pass));

        // Single-entry scan.
        ready_mode = 3;
        done_cnt_a = 0;
        pulse_start_a(7'd0);
        wait_idle_a(100, "one");
        build_exp(0, 1);
        cmp_words("one");
        exp_pass++;
        chk16("one_done", 16'(done_cnt_a), 16'd1);
        chk16("one_pass", pc_a, 16'(exp_pass));

        // Random tables, limits and backpressure.
        for (int k = 0; k < 3; k++) begin
            rand_table();
            li = (k == 0) ? 127 : int'($urandom_range(1, 126));
            done_cnt_a = 0;
            pulse_start_a(7'(li));
            wait_idle_a(2000, $sformatf("rnd%0d", k));
            build_exp(li, 1);
            cmp_words($sformatf("rnd%0d", k));
            exp_pass++;
            chk16($sformatf("rnd%0d_pass", k), pc_a, 16'(exp_pass));
        end

        // Reset while a word is presented.
        ready_mode = 2;
        hold_idx   = 7'd2;
        hold_en    = 1'b1;
        pulse_start_a(7'd10);
        n = 0;
        while (!(valid_a && data_a[14:8] == 7'd2) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk16("rstmid_reach2", 16'(valid_a), 16'd1);
        tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk16("rstmid_valid", 16'(valid_a), 16'd0);
        chk16("rstmid_index", 16'(idx_a), 16'd0);
        chk16("rstmid_busy", 16'(busy_a), 16'd0);
        chk16("rstmid_pass", pc_a, 16'd0);
        tick();
        reset      = 1'b0;
        hold_en    = 1'b0;
        ready_mode = 0;
        got_a.delete();
        done_cnt_a = 0;
        exp_pass   = 0;
        pulse_start_a(7'd2);
        wait_idle_a(100, "after_rst");
        build_exp(2, 1);
        cmp_words("after_rst");
        exp_pass++;
        chk16("after_rst_pass", pc_a, 16'(exp_pass));

        // 64-entry instance: limit 127 clamps to 63.
        rand_table();
        got_b.delete();
        done_cnt_b = 0;
        tick();
        last_idx = 7'h7F;
        start_b  = 1'b1;
        tick();
        start_b  = 1'b0;
        n = 0;
        @(negedge clk);
        while (busy_b && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk16("clamp_idle", 16'(busy_b), 16'd0);
        chk16("clamp_count", 16'(got_b.size()), 16'd64);
        for (int i = 0; i < 64 && i < got_b.size(); i++)
            chk16($sformatf("clamp_w%0d", i), got_b[i], word_of(i));
        chk16("clamp_done", 16'(done_cnt_b), 16'd1);
        chk16("clamp_pass", pc_b, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/remap_table_scanner.md
Name: remap_table_scanner

Overview:
Read-side companion to the 128-entry 7-bit channel remap register file. The scanner drives the lookup index into the table and captures the remapped value the table returns. It emits a stream of packed {index, remapped} words, so the host can dump the whole table, or a prefix of it, through a pipe-out FIFO. It also supplies the sensor sequencer with the remapped channel order. It sits between the remap register file's lookup port and a valid/ready consumer (pipe-out FIFO or sequencer).

Parameters:
NUM_ENTRIES, 128, table depth; the last legal index is NUM_ENTRIES-1.
IDX_W, 7, width of the index and of the remapped value.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high; when high, all state returns to IDLE.
start  input  1  single-cycle request to begin a scan; sampled only in IDLE.
continuous  input  1  1 = rescan from index 0 after the last entry; sampled at the end of each pass.
abort  input  1  terminates the scan at the next word boundary.
last_idx  input  IDX_W  last index to scan; latched at start; values above NUM_ENTRIES-1 are clamped to NUM_ENTRIES-1.
index_number  output  IDX_W  registered lookup address driven into the remap table.
index_number_remapped  input  IDX_W  combinational table output for index_number.
m_valid  output  1  output word valid.
m_ready  input  1  consumer accepts the word when m_valid && m_ready.
m_data  output  16  {1'b0, index, 1'b0, remapped}: bits 14:8 = index, bits 6:0 = remapped value.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse when a pass completes or an abort takes effect.
pass_count  output  16  number of completed passes since reset; saturates at 16'hFFFF.

Behaviour:
- Reset values: index_number=0, m_valid=0, m_data=0, busy=0, done=0, pass_count=0, state=IDLE. Reset mid-scan drops any pending word without handshake; m_valid is low in the cycle after reset is asserted.
- States: IDLE, ADDR, CAPT, OUT, DONE.
- IDLE: on start=1, latch lim=min(last_idx, NUM_ENTRIES-1), set index_number=0, go to ADDR. start in any other state is ignored.
- ADDR: one settle cycle for the table lookup; go to CAPT.
- CAPT: register m_data={1'b0,index_number,1'b0,index_number_remapped}, set m_valid=1, go to OUT.
- OUT: m_valid and m_data hold stable until m_ready=1. On the handshake cycle:
  - if abort has been seen (sticky flag, set whenever abort=1 while busy) -> DONE.
  - else if index_number==lim: increment pass_count (saturating). If continuous=1, set index_number=0 and go to ADDR; otherwise go to DONE.
  - else increment index_number and go to ADDR.
- abort never truncates a presented word; the word in flight completes its handshake first. A done pulse fires for an abort-terminated scan. pass_count increments only on complete passes.
- DONE: done=1 for one cycle, m_valid=0, clear the abort flag, return to IDLE. In continuous mode, done also pulses for one cycle on every pass completion, concurrent with the transition back to ADDR.
- Latency: start at edge T0 -> index_number=0 after T0 -> m_valid=1 after edge T2. Throughput with m_ready held high: one word per 3 cycles.
- Boundary conditions:
  - last_idx=0 scans exactly one word.
  - last_idx>=127 scans all 128 entries.
  - index_number never exceeds lim, and wraps only to 0.
  - start and abort high in the same IDLE cycle: the scan starts with abort already flagged, emits word 0, then goes to DONE.
- Table writes during a scan are not blocked. Each word reflects the table contents at its CAPT cycle.

Test Plan:
- Table preloaded with entry i = 127-i; start, last_idx=127, continuous=0, m_ready=1 -> 128 words, first m_data=16'h007F, last 16'h7F00; one done pulse; pass_count=1; busy low afterwards.
- last_idx=3, m_ready toggling 1/0 each cycle -> exactly 4 words with index 0..3; m_data stable during every stall cycle; no word dropped or duplicated.
- last_idx=1, continuous=1 for 3 passes, then deassert -> word index sequence 0,1,0,1,0,1; three done pulses; pass_count=3.
- abort asserted while word index 5 is stalled (m_ready=0) -> word 5 is still delivered when m_ready rises; no index-6 word; done pulses; pass_count is unchanged.
- reset asserted while in OUT with m_valid=1 -> m_valid=0 and index_number=0 on the next cycle; a subsequent start scans from index 0.
- last_idx=7'h7F with NUM_ENTRIES=64 -> clamped to 63; exactly 64 words are emitted.
